// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block: branch-kind encodings,
// FSM state type, statistics counter width and the target-address helper.
package branch_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_BGTU = 4'd7,
        BR_BLTU = 4'd8
    } br_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_RESOLVED = 1'b1
    } state_e;

    // Branch target: PC + 4 plus the word-scaled, sign-extended offset.
    // The 32-bit sum wraps silently.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [15:0] imm);
        logic [31:0] offs;
        offs = {{14{imm[15]}}, imm, 2'b00};
        return pc + 32'd4 + offs;
    endfunction

endpackage

// File: rtl/br_eval.sv
// Combinational branch decision: maps the branch kind and comparator flags
// to a taken bit and flags encodings that are not a known branch kind.
module br_eval
    import branch_pkg::*;
(
    input  logic [3:0] br_op,
    input  logic       equal,
    input  logic       larger,
    input  logic       less,
    input  logic       bez,
    input  logic       bgz,
    input  logic       blz,
    output logic       taken,
    output logic       illegal
);

    // Decode the branch kind into a taken decision; unknown kinds never take.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_op)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = equal;
            BR_BNE:  taken = ~equal;
            BR_BLEZ: taken = bez | blz;
            BR_BGTZ: taken = bgz;
            BR_BLTZ: taken = blz;
            BR_BGEZ: taken = bez | bgz;
            BR_BGTU: taken = larger;
            BR_BLTU: taken = less;
            default: begin
                taken   = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution in decode: accepts a branch when the pipeline is not
// held, registers the redirect target for taken branches, pulses on
// not-taken ones and latches a sticky error for delay-slot branches or
// unknown branch kinds.
// Optional feature: define BRANCH_STATS_EN to build saturating taken /
// not-taken statistics counters; otherwise the counter ports read 0.
module branch_resolve
    import branch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [3:0]       br_op,
    input  logic             equal,
    input  logic             larger,
    input  logic             less,
    input  logic             bez,
    input  logic             bgz,
    input  logic             blz,
    input  logic [31:0]      pc_d,
    input  logic [15:0]      imm16,
    output logic             redirect,
    output logic [31:0]      target,
    output logic             nt_pulse,
    output logic             dslot_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nt_cnt
);

    state_e state_r;
    logic   taken_s;
    logic   illegal_s;

    br_eval u_br_eval (
        .br_op   (br_op),
        .equal   (equal),
        .larger  (larger),
        .less    (less),
        .bez     (bez),
        .bgz     (bgz),
        .blz     (blz),
        .taken   (taken_s),
        .illegal (illegal_s)
    );

    // Resolution FSM with registered redirect, target, pulse and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            redirect  <= 1'b0;
            target    <= 32'd0;
            nt_pulse  <= 1'b0;
            dslot_err <= 1'b0;
        end else begin
            nt_pulse <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A held branch is dropped; the hazard unit re-presents it.
                    if (br_valid && !stall) begin
                        if (illegal_s) begin
                            dslot_err <= 1'b1;
                        end
                        if (taken_s) begin
                            state_r  <= ST_RESOLVED;
                            redirect <= 1'b1;
                            target   <= branch_target(pc_d, imm16);
                        end else begin
                            nt_pulse <= 1'b1;
                        end
                    end
                end
                ST_RESOLVED: begin
                    // Anything arriving here sits in the delay slot.
                    if (br_valid) begin
                        dslot_err <= 1'b1;
                    end
                    if (!stall) begin
                        state_r  <= ST_IDLE;
                        redirect <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    redirect <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic acc_taken_s;
    logic acc_nt_s;

    assign acc_taken_s = (state_r == ST_IDLE) && br_valid && !stall && taken_s;
    assign acc_nt_s    = (state_r == ST_IDLE) && br_valid && !stall && !taken_s;

    // Saturating counts of accepted taken and not-taken branches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt <= {CNT_W{1'b0}};
            nt_cnt    <= {CNT_W{1'b0}};
        end else begin
            if (acc_taken_s && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
            if (acc_nt_s && (nt_cnt != CNT_MAX)) begin
                nt_cnt <= nt_cnt + CNT_ONE;
            end
        end
    end
`else
    assign taken_cnt = {CNT_W{1'b0}};
    assign nt_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve: a vector table of single branches
// plus hand-written sequences for stall hold, delay-slot, illegal op and
// asynchronous reset behaviour.
module tb_branch_resolve;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [3:0]  br_op;
    logic        equal, larger, less, bez, bgz, blz;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic        redirect;
    logic [31:0] target;
    logic        nt_pulse;
    logic        dslot_err;
    logic [15:0] taken_cnt;
    logic [15:0] nt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_tgt;
    int          exp_taken_n;
    int          exp_nt_n;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  flags;   // {equal, larger, less, bez, bgz, blz}
        logic [31:0] pc;
        logic [15:0] imm;
        logic        tk;
        logic [31:0] tgt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    branch_resolve dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_op     (br_op),
        .equal     (equal),
        .larger    (larger),
        .less      (less),
        .bez       (bez),
        .bgz       (bgz),
        .blz       (blz),
        .pc_d      (pc_d),
        .imm16     (imm16),
        .redirect  (redirect),
        .target    (target),
        .nt_pulse  (nt_pulse),
        .dslot_err (dslot_err),
        .taken_cnt (taken_cnt),
        .nt_cnt    (nt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [5:0] fl,
                         input logic [31:0] pc, input logic [15:0] imm);
        br_op = op;
        {equal, larger, less, bez, bgz, blz} = fl;
        pc_d  = pc;
        imm16 = imm;
    endtask

    initial begin
        vecs[0]  = '{4'd1, 6'b100000, 32'h0000_3000, 16'h0004, 1'b1, 32'h0000_3014};
        vecs[1]  = '{4'd2, 6'b000000, 32'h0000_3000, 16'hFFFF, 1'b1, 32'h0000_3000};
        vecs[2]  = '{4'd1, 6'b000000, 32'h0000_3000, 16'h0004, 1'b0, 32'h0000_0000};
        vecs[3]  = '{4'd1, 6'b100000, 32'hFFFF_FFFC, 16'h0001, 1'b1, 32'h0000_0004};
        vecs[4]  = '{4'd2, 6'b100000, 32'h0000_1000, 16'h0001, 1'b0, 32'h0000_0000};
        vecs[5]  = '{4'd3, 6'b000100, 32'h0000_1000, 16'h0010, 1'b1, 32'h0000_1044};
        vecs[6]  = '{4'd3, 6'b000001, 32'h0000_0000, 16'h8000, 1'b1, 32'hFFFE_0004};
        vecs[7]  = '{4'd3, 6'b000010, 32'h0000_1000, 16'h0010, 1'b0, 32'h0000_0000};
        vecs[8]  = '{4'd4, 6'b000010, 32'h0000_2000, 16'h0001, 1'b1, 32'h0000_2008};
        vecs[9]  = '{4'd4, 6'b000100, 32'h0000_2000, 16'h0001, 1'b0, 32'h0000_0000};
        vecs[10] = '{4'd5, 6'b000001, 32'h0000_0100, 16'h0002, 1'b1, 32'h0000_010C};
        vecs[11] = '{4'd5, 6'b000110, 32'h0000_0100, 16'h0002, 1'b0, 32'h0000_0000};
        vecs[12] = '{4'd6, 6'b000100, 32'h0000_0000, 16'h0000, 1'b1, 32'h0000_0004};
        vecs[13] = '{4'd6, 6'b000010, 32'h0000_1000, 16'h0003, 1'b1, 32'h0000_1010};
        vecs[14] = '{4'd6, 6'b000001, 32'h0000_1000, 16'h0003, 1'b0, 32'h0000_0000};
        vecs[15] = '{4'd7, 6'b010000, 32'h0000_4000, 16'h7FFF, 1'b1, 32'h0002_4000};
        vecs[16] = '{4'd7, 6'b001000, 32'h0000_4000, 16'h7FFF, 1'b0, 32'h0000_0000};
        vecs[17] = '{4'd8, 6'b001000, 32'h0000_0500, 16'hFFFE, 1'b1, 32'h0000_04FC};
        vecs[18] = '{4'd8, 6'b010000, 32'h0000_0500, 16'hFFFE, 1'b0, 32'h0000_0000};
        vecs[19] = '{4'd0, 6'b111111, 32'h0000_0600, 16'h0001, 1'b0, 32'h0000_0000};

        reset = 1'b0;
        stall = 1'b0;
        br_valid = 1'b0;
        drive(4'd0, 6'b000000, 32'h0, 16'h0);
        exp_tgt = 32'h0;
        exp_taken_n = 0;
        exp_nt_n = 0;

        // Reset state
        tick();
        tick();
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_nt_pulse", {31'd0, nt_pulse}, 32'd0);
        check("rst_dslot_err", {31'd0, dslot_err}, 32'd0);
        check("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
        check("rst_nt_cnt", {16'd0, nt_cnt}, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_redirect", {31'd0, redirect}, 32'd0);

        // Vector table: one accepted branch each, then an idle cycle
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].flags, vecs[i].pc, vecs[i].imm);
            br_valid = 1'b1;
            stall = 1'b0;
            tick();
            br_valid = 1'b0;
            if (vecs[i].tk) begin
                exp_tgt = vecs[i].tgt;
                exp_taken_n++;
            end else begin
                exp_nt_n++;
            end
            check($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].tk});
            check($sformatf("v%0d_nt_pulse", i), {31'd0, nt_pulse}, {31'd0, ~vecs[i].tk});
            check($sformatf("v%0d_target", i), target, exp_tgt);
            check($sformatf("v%0d_dslot_err", i), {31'd0, dslot_err}, 32'd0);
            tick();
            check($sformatf("v%0d_redirect_after", i), {31'd0, redirect}, 32'd0);
            check($sformatf("v%0d_nt_pulse_after", i), {31'd0, nt_pulse}, 32'd0);
        end

        // Stall hold in RESOLVED: taken BGTZ then three stalled cycles
        drive(4'd4, 6'b000010, 32'h0000_8000, 16'h0020);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        stall = 1'b1;
        exp_tgt = 32'h0000_8084;
        exp_taken_n++;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("hold%0d_redirect", c), {31'd0, redirect}, 32'd1);
            check($sformatf("hold%0d_target", c), target, exp_tgt);
            if (c < 3) tick();
        end
        stall = 1'b0;
        tick();
        check("hold_release_redirect", {31'd0, redirect}, 32'd0);

        // Stalled BLTZ in IDLE has no effect
        drive(4'd5, 6'b000001, 32'h0000_9000, 16'h0001);
        br_valid = 1'b1;
        stall = 1'b1;
        tick();
        check("idle_stall_redirect", {31'd0, redirect}, 32'd0);
        check("idle_stall_nt_pulse", {31'd0, nt_pulse}, 32'd0);
        check("idle_stall_target", target, exp_tgt);
        br_valid = 1'b0;
        stall = 1'b0;
        tick();

        // Statistics counters
`ifdef BRANCH_STATS_EN
        check("taken_cnt", {16'd0, taken_cnt}, exp_taken_n);
        check("nt_cnt", {16'd0, nt_cnt}, exp_nt_n);
`else
        check("taken_cnt_off", {16'd0, taken_cnt}, 32'd0);
        check("nt_cnt_off", {16'd0, nt_cnt}, 32'd0);
`endif

        // Delay-slot branch: BLTU presented while RESOLVED
        drive(4'd1, 6'b100000, 32'h0000_A000, 16'h0001);
        br_valid = 1'b1;
        tick();
        exp_tgt = 32'h0000_A008;
        check("ds_redirect", {31'd0, redirect}, 32'd1);
        drive(4'd8, 6'b001000, 32'h0000_B000, 16'h0004);
        tick();
        br_valid = 1'b0;
        check("ds_dslot_err", {31'd0, dslot_err}, 32'd1);
        check("ds_redirect_drop", {31'd0, redirect}, 32'd0);
        check("ds_nt_pulse", {31'd0, nt_pulse}, 32'd0);
        check("ds_target", target, exp_tgt);
        tick();
        check("ds_ignored_redirect", {31'd0, redirect}, 32'd0);
        check("ds_sticky", {31'd0, dslot_err}, 32'd1);

        // Reset clears the sticky error
        reset = 1'b0;
        tick();
        check("rst2_dslot_err", {31'd0, dslot_err}, 32'd0);
        check("rst2_target", target, 32'd0);
        check("rst2_taken_cnt", {16'd0, taken_cnt}, 32'd0);
        reset = 1'b1;
        tick();

        // Illegal branch kind: not taken, error latched
        drive(4'hF, 6'b111111, 32'h0000_C000, 16'h0001);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("ill_nt_pulse", {31'd0, nt_pulse}, 32'd1);
        check("ill_dslot_err", {31'd0, dslot_err}, 32'd1);
        check("ill_redirect", {31'd0, redirect}, 32'd0);
        tick();
        check("ill_nt_pulse_clear", {31'd0, nt_pulse}, 32'd0);
        check("ill_sticky", {31'd0, dslot_err}, 32'd1);

        // Asynchronous reset in the middle of RESOLVED
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        drive(4'd1, 6'b100000, 32'h0000_3000, 16'h0004);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("ar_redirect_before", {31'd0, redirect}, 32'd1);
        check("ar_target_before", target, 32'h0000_3014);
        #2;
        reset = 1'b0;
        #1;
        check("ar_redirect_async", {31'd0, redirect}, 32'd0);
        check("ar_target_async", target, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_redirect_after", {31'd0, redirect}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous active-low reset; the design is in reset while reset=0.
REQ-003 SHALL have ports: stall  in  1  pipeline hold from the hazard unit.
REQ-004 SHALL have ports: br_valid  in  1  a branch instruction is in D this cycle.
REQ-005 SHALL have ports: br_op  in  4  branch kind, encoded per the shared package.
REQ-006 SHALL have ports: equal, larger, less, bez, bgz, blz  in  1 each  comparator flags for the D-stage operands.
REQ-007 SHALL have ports: pc_d  in  32  PC of the branch; imm16  in  16  branch offset field.
REQ-008 SHALL have ports: redirect  out  1  fetch must load target; target  out  32  redirect address.
REQ-009 SHALL have ports: nt_pulse  out  1  one-cycle not-taken indication.
REQ-010 SHALL have ports: dslot_err  out  1  sticky flag for a branch in a delay slot, or an illegal op.
REQ-011 SHALL have ports: taken_cnt, nt_cnt  out  16 each  statistics counters.

Function
REQ-012 SHALL evaluate taken per br_op: BEQ=equal; BNE=!equal; BLEZ=bez|blz; BGTZ=bgz; BLTZ=blz; BGEZ=bez|bgz; BGTU=larger; BLTU=less; NONE=0.
REQ-013 SHALL treat any unlisted br_op with br_valid=1 as not taken and set dslot_err.
REQ-014 SHALL compute target = pc_d + 4 + (sign_extend(imm16) << 2) modulo 2^32, with silent wrap-around.
REQ-015 SHALL use two states, IDLE and RESOLVED.
REQ-016 In IDLE, br_valid=1 with stall=0 SHALL sample the decision at the clock edge.
REQ-017 If the sampled decision is taken, the block SHALL register target and enter RESOLVED; if not taken, it SHALL stay in IDLE.
REQ-018 In IDLE, br_valid=1 with stall=1 SHALL be ignored; the hazard unit re-presents the branch.
REQ-019 redirect SHALL be 1 exactly while in RESOLVED, i.e. one cycle after acceptance (latency 1).
REQ-020 target SHALL remain stable for the whole RESOLVED interval.
REQ-021 In RESOLVED, stall=1 SHALL hold the state, redirect and target; stall=0 SHALL return to IDLE at the next edge.
REQ-022 br_valid=1 in RESOLVED (a branch in the delay slot) SHALL be ignored and SHALL set dslot_err.
REQ-023 nt_pulse SHALL be 1 for exactly one cycle, the cycle after a not-taken acceptance.
REQ-024 dslot_err SHALL remain set until reset.

Reset
REQ-025 Asserting reset SHALL asynchronously force: state=IDLE, redirect=0, target=0, nt_pulse=0, dslot_err=0, taken_cnt=0, nt_cnt=0.
REQ-026 Reset asserted during RESOLVED SHALL drop redirect immediately, without waiting for a clock edge.
REQ-027 Reset release SHALL take effect at the first rising edge after reset=1.

Configuration
REQ-028 Macro BRANCH_STATS_EN defined: taken_cnt and nt_cnt SHALL increment on each taken or not-taken acceptance respectively, saturating at 16'hFFFF.
REQ-029 Macro BRANCH_STATS_EN undefined: taken_cnt and nt_cnt SHALL be constant 0, the ports SHALL remain present, and no counter flops SHALL be inferred.

Structure
REQ-030 Package branch_pkg SHALL hold: br_op encodings (NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6, BGTU=7, BLTU=8), the state enum, and the counter width constant (16).
REQ-031 Sub-module br_eval SHALL contain the combinational taken decision (br_op plus flags to taken, illegal); the FSM, target and counters SHALL stay in branch_resolve.

Verification
REQ-032 Taken branch: pc_d=32'h0000_3000, imm16=16'h0004, BEQ, equal=1, stall=0 -> next cycle redirect=1, target=32'h0000_3014; IDLE the cycle after.
REQ-033 Negative offset: pc_d=32'h0000_3000, imm16=16'hFFFF, BNE, equal=0 -> target=32'h0000_3000.
REQ-034 Wrap-around: pc_d=32'hFFFF_FFFC, imm16=16'h0001 -> target=32'h0000_0004.
REQ-035 Stall hold: taken BGTZ, then stall=1 for 3 cycles -> redirect=1 for 4 cycles with target unchanged; a BLTZ with stall=1 in IDLE -> no effect.
REQ-036 Error handling: BLTU issued during RESOLVED -> ignored and dslot_err=1; br_op=4'hF with br_valid=1 -> nt_pulse=1, dslot_err=1.
REQ-037 Reset and stats: reset dropped mid-RESOLVED -> redirect=0 in the same cycle; with BRANCH_STATS_EN, 3 taken and 2 not-taken branches -> taken_cnt=3, nt_cnt=2; without the macro, both read 0.
